// File: rtl/clarvi_soc_button_debounce.sv
// Per-bit two-flop synchroniser and counter debouncer for board buttons/switches, with press/release pulses.
// Latency: a steady new input level appears on buttons_db and rise/fall on edge STABLE_CYCLES+2.
// Backpressure: none; free-running level conditioner, every output is a flop.
//
// Ports:
//   clk          system clock, all registers update on its rising edge
//   reset        synchronous, active-high reset (clears every register)
//   buttons_raw  asynchronous raw pin levels (WIDTH bits)
//   buttons_db   debounced levels, feeds the PIO in_port
//   rise / fall  one-cycle pulse per bit when buttons_db goes 0->1 / 1->0
//   changed      OR of rise|fall, registered alongside the pulses
module clarvi_soc_button_debounce #(
    parameter int WIDTH         = 16,
    parameter int STABLE_CYCLES = 50000,
    parameter int INVERT        = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] buttons_raw,
    output logic [WIDTH-1:0] buttons_db,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
);

    // STABLE_CYCLES >= 2, so the counter is always at least one bit wide.
    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] s1;
    logic [WIDTH-1:0] s2;
    logic [CW-1:0]    cnt     [WIDTH];
    logic [CW-1:0]    cnt_nxt [WIDTH];
    logic [WIDTH-1:0] db_nxt;
    logic [WIDTH-1:0] rise_nxt;
    logic [WIDTH-1:0] fall_nxt;

    // Board KEYs are active-low; inverting here makes "pressed" read as 1.
    assign x = (INVERT != 0) ? ~buttons_raw : buttons_raw;

    // Counter tracks the length of the unbroken run where the synchronised
    // input disagrees with the debounced state; any agreeing cycle clears it.
    always_comb begin
        db_nxt = buttons_db;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (s2[i] != buttons_db[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    db_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
        rise_nxt = db_nxt & ~buttons_db;
        fall_nxt = ~db_nxt & buttons_db;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            buttons_db <= '0;
            rise       <= '0;
            fall       <= '0;
            changed    <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1         <= x;
            s2         <= s1;
            buttons_db <= db_nxt;
            rise       <= rise_nxt;
            fall       <= fall_nxt;
            changed    <= |(rise_nxt | fall_nxt);
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

endmodule

// File: tb/tb_clarvi_soc_button_debounce.sv
// Self-checking bench for clarvi_soc_button_debounce (STABLE_CYCLES=4).
// Instance a uses INVERT=1, instance b uses INVERT=0.
// Reference model: a level is accepted once the last S synchronised samples all disagree with it.
module tb_clarvi_soc_button_debounce;

    localparam int S = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] raw_a = 16'hFFFF;
    logic [15:0] raw_b = 16'h0000;
    logic [15:0] db_a, rise_a, fall_a, db_b, rise_b, fall_b;
    logic        chg_a, chg_b;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    clarvi_soc_button_debounce #(.WIDTH(16), .STABLE_CYCLES(S), .INVERT(1)) dut_a (
        .clk(clk), .reset(reset), .buttons_raw(raw_a),
        .buttons_db(db_a), .rise(rise_a), .fall(fall_a), .changed(chg_a)
    );

    clarvi_soc_button_debounce #(.WIDTH(16), .STABLE_CYCLES(S), .INVERT(0)) dut_b (
        .clk(clk), .reset(reset), .buttons_raw(raw_b),
        .buttons_db(db_b), .rise(rise_b), .fall(fall_b), .changed(chg_b)
    );

    // Reference model state, index 0 = instance a, 1 = instance b.
    logic [15:0] m_s1 [2];
    logic [15:0] m_s2 [2];
    logic [15:0] m_db [2];
    logic [15:0] m_rise [2];
    logic [15:0] m_fall [2];
    logic        m_chg [2];
    logic [15:0] m_win [2][S];   // most recent S synchronised samples, [0] newest
    int          m_n [2];        // valid samples in the window since reset

    initial begin
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = '0; m_s2[k] = '0; m_db[k] = '0;
            m_rise[k] = '0; m_fall[k] = '0; m_chg[k] = 1'b0; m_n[k] = 0;
            for (int j = 0; j < S; j++) m_win[k][j] = '0;
        end
    end

    // Advance one clock edge, update the model with the inputs seen at that edge,
    // then step 1 time unit past the edge so outputs can be sampled.
    task automatic tick();
        logic [15:0] xin [2];
        logic [15:0] nd;
        logic        all_diff;
        xin[0] = ~raw_a;
        xin[1] = raw_b;
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_s1[k] = '0; m_s2[k] = '0; m_db[k] = '0;
                m_rise[k] = '0; m_fall[k] = '0; m_chg[k] = 1'b0; m_n[k] = 0;
            end else begin
                for (int j = S - 1; j > 0; j--) m_win[k][j] = m_win[k][j-1];
                m_win[k][0] = m_s2[k];
                if (m_n[k] < S) m_n[k]++;
                m_s2[k] = m_s1[k];
                m_s1[k] = xin[k];
                nd = m_db[k];
                for (int b = 0; b < 16; b++) begin
                    all_diff = (m_n[k] == S);
                    for (int j = 0; j < S; j++)
                        if (m_win[k][j][b] == m_db[k][b]) all_diff = 1'b0;
                    if (all_diff) nd[b] = ~m_db[k][b];
                end
                m_rise[k] = nd & ~m_db[k];
                m_fall[k] = ~nd & m_db[k];
                m_chg[k]  = |(m_rise[k] | m_fall[k]);
                m_db[k]   = nd;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; raw_a = 16'hFFFF; raw_b = 16'h0000;
        for (int e = 0; e < 6; e++) begin
            if (e == 2) reset = 1'b0;
            tick();
            vectors++;
            if ({db_a, rise_a, fall_a, chg_a} !== 49'd0) begin
                miscompares++;
                $display("FAIL reset_a cyc%0d got db=%h r=%h f=%h c=%b want all 0", e, db_a, rise_a, fall_a, chg_a);
            end
            vectors++;
            if ({db_b, rise_b, fall_b, chg_b} !== 49'd0) begin
                miscompares++;
                $display("FAIL reset_b cyc%0d got db=%h r=%h f=%h c=%b want all 0", e, db_b, rise_b, fall_b, chg_b);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [48:0] exp;
        raw_a = 16'hFFFE;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = {(e >= 6) ? 16'h0001 : 16'h0000, (e == 6) ? 16'h0001 : 16'h0000, 16'h0000, e == 6};
            vectors++;
            if ({db_a, rise_a, fall_a, chg_a} !== exp) begin
                miscompares++;
                $display("FAIL press edge%0d got %h/%h/%h/%b want %h", e, db_a, rise_a, fall_a, chg_a, exp);
            end
        end
        raw_a = 16'hFFFF;
        for (int e = 1; e <= 8; e++) begin
            tick();
            exp = {(e >= 6) ? 16'h0000 : 16'h0001, 16'h0000, (e == 6) ? 16'h0001 : 16'h0000, e == 6};
            vectors++;
            if ({db_a, rise_a, fall_a, chg_a} !== exp) begin
                miscompares++;
                $display("FAIL release edge%0d got %h/%h/%h/%b want %h", e, db_a, rise_a, fall_a, chg_a, exp);
            end
        end
    endtask

    task automatic test_bounce();
        int found = 0;
        for (int c = 0; c < 20; c++) begin
            raw_a = (((c / 2) % 2) == 0) ? 16'hFFF7 : 16'hFFFF;
            tick();
            vectors++;
            if ({db_a, rise_a, fall_a, chg_a} !== 49'd0) begin
                miscompares++;
                $display("FAIL bounce cyc%0d got %h/%h/%h/%b want all 0", c, db_a, rise_a, fall_a, chg_a);
            end
        end
        raw_a = 16'hFFF7;
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (db_a[3] && found == 0) begin
                found = e;
                vectors++;
                if (rise_a !== 16'h0008) begin
                    miscompares++;
                    $display("FAIL bounce_rise got %h want 0008", rise_a);
                end
            end
        end
        vectors++;
        if (found !== 6) begin
            miscompares++;
            $display("FAIL bounce_latency got %0d edges want 6 (0 = never)", found);
        end
    endtask

    task automatic test_simultaneous();
        raw_a = 16'hFFFF;
        for (int e = 0; e < 10; e++) tick();
        vectors++;
        if (db_a !== 16'h0000) begin
            miscompares++;
            $display("FAIL simul_pre got %h want 0000", db_a);
        end
        raw_a = 16'h7F7E;
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++;
            if ({rise_a, chg_a} !== {(e == 6) ? 16'h8081 : 16'h0000, e == 6}) begin
                miscompares++;
                $display("FAIL simul edge%0d got rise=%h c=%b want rise=%h", e, rise_a, chg_a, (e == 6) ? 16'h8081 : 16'h0000);
            end
        end
        vectors++;
        if (db_a !== 16'h8081) begin
            miscompares++;
            $display("FAIL simul_db got %h want 8081", db_a);
        end
        raw_a = 16'hFFFF;
        for (int e = 0; e < 10; e++) tick();
    endtask

    task automatic test_reset_mid_count();
        int found = 0;
        int pulses = 0;
        raw_a = 16'hFFFB;
        for (int e = 1; e <= 3; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({db_a, rise_a, fall_a, chg_a} !== 49'd0) begin
            miscompares++;
            $display("FAIL midreset_clear got %h/%h/%h/%b want all 0", db_a, rise_a, fall_a, chg_a);
        end
        for (int e = 1; e <= 10; e++) begin
            tick();
            if (rise_a[2]) pulses++;
            if (db_a[2] && found == 0) found = e;
        end
        vectors++;
        if (found !== 6 || pulses !== 1) begin
            miscompares++;
            $display("FAIL midreset_accept got edge %0d pulses %0d want edge 6 pulses 1", found, pulses);
        end
        // Reset landing on the very edge where a flip is due must win.
        raw_a = 16'hFFFF;
        for (int e = 0; e < 10; e++) tick();
        raw_a = 16'hFFFB;
        for (int e = 1; e <= 5; e++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        vectors++;
        if ({db_a, rise_a, chg_a} !== 33'd0) begin
            miscompares++;
            $display("FAIL reset_priority got db=%h rise=%h c=%b want 0", db_a, rise_a, chg_a);
        end
        raw_a = 16'hFFFF;
        for (int e = 0; e < 10; e++) tick();
    endtask

    task automatic test_no_invert();
        raw_b = 16'h0002;
        for (int e = 1; e <= 7; e++) begin
            tick();
            vectors++;
            if ({db_b, rise_b} !== {(e >= 6) ? 16'h0002 : 16'h0000, (e == 6) ? 16'h0002 : 16'h0000}) begin
                miscompares++;
                $display("FAIL noinv edge%0d got db=%h rise=%h", e, db_b, rise_b);
            end
        end
        raw_b = 16'h0000;
        for (int e = 0; e < 10; e++) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            raw_a = raw_a ^ 16'($urandom & $urandom & $urandom);
            raw_b = raw_b ^ 16'($urandom & $urandom & $urandom);
            reset = ($urandom_range(0, 99) == 0);
            tick();
            vectors++;
            if ({db_a, rise_a, fall_a, chg_a} !== {m_db[0], m_rise[0], m_fall[0], m_chg[0]}) begin
                miscompares++;
                $display("FAIL rand_a cyc%0d got %h/%h/%h/%b want %h/%h/%h/%b", c, db_a, rise_a, fall_a, chg_a,
                         m_db[0], m_rise[0], m_fall[0], m_chg[0]);
            end
            vectors++;
            if ({db_b, rise_b, fall_b, chg_b} !== {m_db[1], m_rise[1], m_fall[1], m_chg[1]}) begin
                miscompares++;
                $display("FAIL rand_b cyc%0d got %h/%h/%h/%b want %h/%h/%h/%b", c, db_b, rise_b, fall_b, chg_b,
                         m_db[1], m_rise[1], m_fall[1], m_chg[1]);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_simultaneous();
        test_reset_mid_count();
        test_no_invert();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
